gates_n_unit: RTL and testbench
===============================

Name: gates_n_unit

Overview:
- Parametrised, registered N-bit logic unit; successor to the single-bit 2-input AND/OR gate primitives.
- Applies a selectable bitwise op to two WIDTH-bit operands behind valid/ready handshakes.
- Single-beat mode: one result per accepted beat.
- Accumulate mode: reduces a multi-beat burst into one result.
- Used wherever the datapath needs bus-wide masking or reduction with flow control.

Parameters:
- WIDTH, 8: operand/result width in bits (>=1).
- CNT_W, 8: width of the beat counter output (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- i1  in  WIDTH  operand 1.
- i2  in  WIDTH  operand 2.
- op  in  2  operation select; sampled on the first beat of a transaction only.
- acc  in  1  1 = accumulate mode; sampled on the first beat only.
- last  in  1  final beat of an accumulate burst; ignored when acc=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- o  out  WIDTH  result.
- cnt  out  CNT_W  beats folded into o, saturating.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, o=0, cnt=0, state=IDLE, partial=0, latched op=0.
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - Result consumed when out_valid & out_ready.
  - in_ready = !out_valid | out_ready, in every state.
  - o and cnt hold stable while out_valid & !out_ready.
- Op encoding:
  - 00 AND, 01 OR, 10 NAND, 11 NOR.
  - Base op b(op): AND for 00/10, OR for 01/11.
  - Inverting variants: 10 and 11.
- State IDLE, accepted beat with acc=0:
  - o <= i1 op i2; cnt <= 1; out_valid <= 1 next cycle (latency 1).
  - State stays IDLE.
- State IDLE, accepted beat with acc=1, last=0:
  - partial <= i1 b i2; op is latched; cnt_int <= 1; go to ACC.
  - No output is produced.
- State IDLE, accepted beat with acc=1, last=1: identical to acc=0.
- State ACC, accepted beat:
  - partial <= partial b (i1 b i2), using the latched op.
  - op and acc inputs are ignored.
  - cnt_int increments, saturating at 2^CNT_W-1.
- State ACC, accepted beat with last=1:
  - o <= final partial, inverted if the latched op is inverting; cnt <= cnt_int.
  - out_valid <= 1 next cycle; go to IDLE.
- Simultaneous consume and accept: permitted in the same cycle; the new result loads and out_valid stays 1 (full throughput, one result per cycle).
- Reset mid-burst: partial is discarded, state returns to IDLE, any pending result is dropped.
- All arithmetic is unsigned. The counter never wraps.

Optional Feature:
- Macro: GATES_XOR_EN.
- Defined: op 10 = XOR, op 11 = XNOR. Base op for both is XOR; XNOR inverts the final result, in accumulate mode as well.
- Undefined: op 10 = NAND, op 11 = NOR, as specified above. No XOR logic is synthesised.

Decomposition:
- Package gates_pkg holds:
  - op encoding constants (OP_AND, OP_OR, OP_NAND_XOR, OP_NOR_XNOR);
  - state type (IDLE, ACC);
  - helper functions is_inverting(op) and base_op(op).
- Sub-module gates_n_comb:
  - purely combinational WIDTH-bit bitwise op of i1/i2 under op select;
  - the N-bit generalisation of the 2-input gates;
  - instantiated twice: once for operand combine, once for partial fold.

Test Plan:
1. Single AND: WIDTH=8, i1=0xF0, i2=0x3C, op=00, acc=0 -> next cycle out_valid=1, o=0x30, cnt=1.
2. Backpressure: result pending, out_ready=0 for 3 cycles -> in_ready=0, o/cnt stable. Set out_ready=1 -> in_ready=1 the same cycle; a new beat is accepted back-to-back.
3. Accumulate OR, 3 beats: (0x01,0x02), (0x04,0x00), (0x80,0x10,last) -> o=0x97, cnt=3, one cycle after last. No out_valid during beats 1-2.
4. Inverting op, single: i1=0x0F, i2=0x0C, op=11 -> o=0xF0 without the macro; o=0xFC with GATES_XOR_EN.
5. Reset mid-burst: two acc beats, then rst=1 for one cycle -> out_valid=0. A subsequent single AND 0xFF & 0x55 -> o=0x55, cnt=1, with no stale partial.
6. Counter saturation: CNT_W=2, 5-beat AND burst of 0xFF/0xFF pairs -> o=0xFF, cnt=3.

Source files
------------

// File: rtl/gates_n_unit_pkg.sv
// gates_pkg: shared definitions for the gates_n_unit logic unit.
//   - op encoding constants (OP_AND, OP_OR, OP_NAND_XOR, OP_NOR_XNOR)
//   - FSM state type (IDLE, ACC)
//   - helpers is_inverting(op) and base_op(op)
// Optional feature macro: GATES_XOR_EN (op 10/11 become XOR/XNOR instead
// of NAND/NOR).
package gates_pkg;

  typedef enum logic [1:0] {
    OP_AND      = 2'b00,
    OP_OR       = 2'b01,
    OP_NAND_XOR = 2'b10,
    OP_NOR_XNOR = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // True when the final result is the complement of the base-op reduction.
  function automatic logic is_inverting(input logic [1:0] op);
`ifdef GATES_XOR_EN
    return (op == OP_NOR_XNOR);
`else
    return op[1];
`endif
  endfunction

  // Non-inverting operator used for combining operands and folding beats.
  function automatic logic [1:0] base_op(input logic [1:0] op);
`ifdef GATES_XOR_EN
    return op[1] ? OP_NAND_XOR : op;
`else
    return {1'b0, op[0]};
`endif
  endfunction

endpackage

// File: rtl/gates_n_unit_if.sv
// gates_n_unit_if: handshake bus of the gates_n_unit logic unit.
//   Input side : in_valid, in_ready, i1, i2, op, acc, last
//   Output side: out_valid, out_ready, o, cnt
// Modports: master (traffic source/sink, e.g. a bench), slave (the unit).
interface gates_n_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [1:0]       op;
  logic             acc;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic [CNT_W-1:0] cnt;

  modport master (
    output in_valid, i1, i2, op, acc, last, out_ready,
    input  in_ready, out_valid, o, cnt
  );

  modport slave (
    input  in_valid, i1, i2, op, acc, last, out_ready,
    output in_ready, out_valid, o, cnt
  );
endinterface

// File: rtl/gates_n_unit_comb.sv
// gates_n_comb: purely combinational WIDTH-bit bitwise gate.
//   a, b : operands
//   op   : 00 AND, 01 OR, 10 NAND (XOR), 11 NOR (XNOR)
//   y    : result
// Optional feature macro: GATES_XOR_EN selects XOR/XNOR for op 10/11.
module gates_n_comb
  import gates_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:      y = a & b;
      OP_OR:       y = a | b;
`ifdef GATES_XOR_EN
      OP_NAND_XOR: y = a ^ b;
      OP_NOR_XNOR: y = ~(a ^ b);
`else
      OP_NAND_XOR: y = ~(a & b);
      OP_NOR_XNOR: y = ~(a | b);
`endif
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/gates_n_unit.sv
// gates_n_unit: registered N-bit logic unit with valid/ready handshakes.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : gates_n_unit_if slave (in_valid/in_ready/i1/i2/op/acc/last in,
//         out_valid/out_ready/o/cnt out)
// Single-beat mode produces one result per beat; accumulate mode folds a
// burst (terminated by last) into one result with a saturating beat count.
// Optional feature macro: GATES_XOR_EN (op 10/11 = XOR/XNOR).
module gates_n_unit
  import gates_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  gates_n_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [CNT_W-1:0] cnt_int_q, cnt_int_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [1:0]       op_eff;
  logic [WIDTH-1:0] beat_b;
  logic [WIDTH-1:0] fold_b;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Inside a burst the latched op governs; the op input is ignored.
  assign op_eff  = (state_q == ACC) ? op_q : bus.op;
  assign cnt_inc = sat_inc(cnt_int_q);

  gates_n_comb #(.WIDTH(WIDTH)) u_combine (
    .a  (bus.i1),
    .b  (bus.i2),
    .op (base_op(op_eff)),
    .y  (beat_b)
  );

  gates_n_comb #(.WIDTH(WIDTH)) u_fold (
    .a  (partial_q),
    .b  (beat_b),
    .op (base_op(op_q)),
    .y  (fold_b)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      partial_q   <= '0;
      cnt_int_q   <= '0;
      o_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      partial_q   <= partial_d;
      cnt_int_q   <= cnt_int_d;
      o_q         <= o_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    if (bus.acc && !bus.last) state_d = ACC;
        ACC:     if (bus.last)             state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and datapath next values
  always_comb begin
    bus.in_ready = !out_valid_q || bus.out_ready;
    accept       = bus.in_valid && bus.in_ready;
    op_d         = op_q;
    partial_d    = partial_q;
    cnt_int_d    = cnt_int_q;
    o_d          = o_q;
    cnt_d        = cnt_q;
    // A consumed result clears out_valid unless a new one loads below.
    out_valid_d  = out_valid_q && !bus.out_ready;
    if (accept) begin
      if (state_q == IDLE) begin
        if (bus.acc && !bus.last) begin
          partial_d = beat_b;
          op_d      = bus.op;
          cnt_int_d = CNT_W'(1);
        end else begin
          o_d         = is_inverting(bus.op) ? ~beat_b : beat_b;
          cnt_d       = CNT_W'(1);
          out_valid_d = 1'b1;
        end
      end else begin
        partial_d = fold_b;
        cnt_int_d = cnt_inc;
        if (bus.last) begin
          o_d         = is_inverting(op_q) ? ~fold_b : fold_b;
          cnt_d       = cnt_inc;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.o         = o_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_gates_n_unit.sv
module tb_gates_n_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gates_n_unit_if #(.WIDTH(8), .CNT_W(8)) bus ();
  gates_n_unit_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  gates_n_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gates_n_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic acc, input logic last);
    bus.in_valid = 1'b1;
    bus.i1 = a;
    bus.i2 = b;
    bus.op = op;
    bus.acc = acc;
    bus.last = last;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.i1 = 0; bus.i2 = 0; bus.op = 0; bus.acc = 0; bus.last = 0;
    bus.out_ready = 1;
    bus2.in_valid = 0; bus2.i1 = 0; bus2.i2 = 0; bus2.op = 0; bus2.acc = 0; bus2.last = 0;
    bus2.out_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.o !== 8'h00 || bus.cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b o=%h cnt=%0d want v=0 o=00 cnt=0",
               bus.out_valid, bus.o, bus.cnt);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_and();
    beat(8'hF0, 8'h3C, 2'b00, 1'b0, 1'b0);
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== 8'h30 || bus.cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_and got v=%b o=%h cnt=%0d want v=1 o=30 cnt=1",
               bus.out_valid, bus.o, bus.cnt);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_and_consumed got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 0;
    beat(8'hAA, 8'h0F, 2'b00, 1'b0, 1'b0);
    step();
    bus.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.o !== 8'h0A || bus.cnt !== 8'd1) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] got rdy=%b v=%b o=%h cnt=%0d want rdy=0 v=1 o=0a cnt=1",
                 i, bus.in_ready, bus.out_valid, bus.o, bus.cnt);
      end
      step();
    end
    bus.out_ready = 1;
    beat(8'h11, 8'h22, 2'b01, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release_ready got %b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== 8'h33 || bus.cnt !== 8'd1) begin
      failures++;
      $display("FAIL backpressure_next got v=%b o=%h cnt=%0d want v=1 o=33 cnt=1",
               bus.out_valid, bus.o, bus.cnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_o [3];
    exp_o[0] = 8'h0F; exp_o[1] = 8'hF3; exp_o[2] = 8'h3C;
    beat(8'h0F, 8'hFF, 2'b00, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== exp_o[0]) begin
      failures++;
      $display("FAIL b2b_0 got v=%b o=%h want v=1 o=%h", bus.out_valid, bus.o, exp_o[0]);
    end
    beat(8'hF0, 8'h03, 2'b01, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== exp_o[1]) begin
      failures++;
      $display("FAIL b2b_1 got v=%b o=%h want v=1 o=%h", bus.out_valid, bus.o, exp_o[1]);
    end
    // acc=1 with last=1 in IDLE behaves as a single beat
    beat(8'h3C, 8'hFF, 2'b00, 1'b1, 1'b1);
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== exp_o[2] || bus.cnt !== 8'd1) begin
      failures++;
      $display("FAIL b2b_2 got v=%b o=%h cnt=%0d want v=1 o=%h cnt=1",
               bus.out_valid, bus.o, bus.cnt, exp_o[2]);
    end
    step();
  endtask

  task automatic test_acc_or();
    beat(8'h01, 8'h02, 2'b01, 1'b1, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_or_beat1 got v=%b want 0", bus.out_valid);
    end
    // op/acc changed mid-burst must be ignored
    beat(8'h04, 8'h00, 2'b00, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_or_beat2 got v=%b want 0", bus.out_valid);
    end
    beat(8'h80, 8'h10, 2'b00, 1'b0, 1'b1);
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== 8'h97 || bus.cnt !== 8'd3) begin
      failures++;
      $display("FAIL acc_or_result got v=%b o=%h cnt=%0d want v=1 o=97 cnt=3",
               bus.out_valid, bus.o, bus.cnt);
    end
    step();
  endtask

  task automatic test_invert();
    logic [7:0] exp_single;
`ifdef GATES_XOR_EN
    exp_single = 8'hFC;
`else
    exp_single = 8'hF0;
`endif
    beat(8'h0F, 8'h0C, 2'b11, 1'b0, 1'b0);
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== exp_single) begin
      failures++;
      $display("FAIL invert_single got v=%b o=%h want v=1 o=%h", bus.out_valid, bus.o, exp_single);
    end
    step();
    // op 10 burst: NAND gives ~(0F & F3) = FC; XOR gives F0 ^ 0C = FC
    beat(8'hFF, 8'h0F, 2'b10, 1'b1, 1'b0);
    step();
    beat(8'hF3, 8'hFF, 2'b01, 1'b0, 1'b1);
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== 8'hFC || bus.cnt !== 8'd2) begin
      failures++;
      $display("FAIL invert_acc got v=%b o=%h cnt=%0d want v=1 o=fc cnt=2",
               bus.out_valid, bus.o, bus.cnt);
    end
    step();
  endtask

  task automatic test_reset_midburst();
    beat(8'h0F, 8'h0F, 2'b00, 1'b1, 1'b0);
    step();
    beat(8'h0F, 8'h0F, 2'b00, 1'b1, 1'b0);
    step();
    bus.in_valid = 0;
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.o !== 8'h00 || bus.cnt !== 8'd0) begin
      failures++;
      $display("FAIL midburst_reset got v=%b o=%h cnt=%0d want v=0 o=00 cnt=0",
               bus.out_valid, bus.o, bus.cnt);
    end
    beat(8'hFF, 8'h55, 2'b00, 1'b0, 1'b0);
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== 8'h55 || bus.cnt !== 8'd1) begin
      failures++;
      $display("FAIL midburst_after got v=%b o=%h cnt=%0d want v=1 o=55 cnt=1",
               bus.out_valid, bus.o, bus.cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1; bus2.i1 = 8'hFF; bus2.i2 = 8'hFF; bus2.op = 2'b00;
      bus2.acc = 1; bus2.last = (i == 4);
      step();
      if (i < 4) begin
        checks++;
        if (bus2.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL sat_beat%0d got v=%b want 0", i, bus2.out_valid);
        end
      end
    end
    bus2.in_valid = 0;
    checks++;
    if (bus2.out_valid !== 1'b1 || bus2.o !== 8'hFF || bus2.cnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_result got v=%b o=%h cnt=%0d want v=1 o=ff cnt=3",
               bus2.out_valid, bus2.o, bus2.cnt);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_and();
    test_backpressure();
    test_back_to_back();
    test_acc_or();
    test_invert();
    test_reset_midburst();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
